// File: rtl/axi_pkg.sv
// Shared constants for the AXI read arbiter.
//   ARB_*       : 2-bit arbiter state encoding (IDLE / ADDR / DATA)
//   AXI_*       : fixed AR-channel attributes driven toward memory
//   REQ_F/REQ_L : requester indices (fetch = 0, load = 1)
package axi_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_L = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_ADDR = ARB_ADDR,
    ST_DATA = ARB_DATA
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker, purely combinational.
//   req[1:0]   : request vector (bit 0 = fetch, bit 1 = load)
//   last_grant : index granted most recently (register lives in the parent)
//   grant      : chosen index, meaningful only when valid
//   valid      : at least one request present
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = REQ_F;
    if (req == 2'b11) begin
      // Tie: the side that did not win last time goes first.
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = REQ_L;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port (AR + R) between instruction fetch (F) and the
// load unit (L). One transaction is outstanding at a time; the grant is held
// from AR issue until the last R beat. A fetch flush drains the remaining
// beats of an in-flight fetch burst internally.
//   f_* / l_*   : requester AR handshake and R delivery per port
//   rdata       : shared read data, qualified by each port's rvalid
//   m_*         : AXI master read port toward memory
//   busy        : arbiter is not idle
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid, once raised, is held with its payload stable until
// the matching ready is seen.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_arvalid,
  input  logic [ADDR_W-1:0] f_araddr,
  input  logic [LEN_W-1:0]  f_arlen,
  output logic              f_arready,
  output logic              f_rvalid,
  output logic              f_rlast,
  input  logic              f_rready,
  input  logic              f_flush,
  input  logic              l_arvalid,
  input  logic [ADDR_W-1:0] l_araddr,
  input  logic [LEN_W-1:0]  l_arlen,
  output logic              l_arready,
  output logic              l_rvalid,
  output logic              l_rlast,
  input  logic              l_rready,
  output logic [DATA_W-1:0] rdata,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;

  logic arb_grant;
  logic arb_valid;
  logic flush_now;
  logic drop_eff;
  logic g_rready;

  // A fetch request raised together with a flush is already stale.
  rr_arb2 u_rr (
    .req        ({l_arvalid, f_arvalid & ~f_flush}),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    f_arready    = 1'b0;
    l_arready    = 1'b0;
    f_rvalid     = 1'b0;
    f_rlast      = 1'b0;
    l_rvalid     = 1'b0;
    l_rlast      = 1'b0;
    rdata        = '0;
    m_rready     = 1'b0;
    g_rready     = 1'b0;
    flush_now    = f_flush & (grant_q == REQ_F);
    // Drop takes effect in the flush cycle itself, not only afterwards.
    drop_eff     = drop_q | flush_now;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          drop_d       = 1'b0;
          state_d      = ST_ADDR;
          if (arb_grant == REQ_F) begin
            f_arready = 1'b1;
            araddr_d  = f_araddr;
            arlen_d   = f_arlen;
          end else begin
            l_arready = 1'b1;
            araddr_d  = l_araddr;
            arlen_d   = l_arlen;
          end
        end
      end
      ST_ADDR: begin
        if (flush_now) drop_d = 1'b1;
        if (m_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        g_rready = (grant_q == REQ_F) ? f_rready : l_rready;
        m_rready = drop_eff | g_rready;
        rdata    = m_rdata;
        if (grant_q == REQ_F) begin
          f_rvalid = m_rvalid & ~drop_eff;
          f_rlast  = m_rlast;
        end else begin
          l_rvalid = m_rvalid;
          l_rlast  = m_rlast;
        end
        if (flush_now) drop_d = 1'b1;
        if (m_rvalid & m_rready & m_rlast) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_F;
      last_grant_q <= REQ_L;
      drop_q       <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
    end
  end

  assign m_arvalid = (state_q == ST_ADDR);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = AXI_SIZE_8B;
  assign m_arburst = AXI_BURST_INCR;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI4 read port (AR + R channels) between the instruction-fetch requester (port 0, F) and the load-unit requester (port 1, L).
- Exactly one transaction is outstanding at a time; the grant is held from AR issue until the last R beat completes.
- Supports fetch flush: on a jump, an in-flight fetch burst is drained internally and never delivered to F.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, read data width
LEN_W, 8, AXI arlen width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
f_arvalid  in  1  fetch read request
f_araddr  in  ADDR_W  fetch address
f_arlen  in  LEN_W  fetch burst length minus 1
f_arready  out  1  fetch request accepted
f_rvalid  out  1  fetch data beat valid
f_rlast  out  1  fetch last beat
f_rready  in  1  fetch can accept a beat
f_flush  in  1  jump: discard current/pending fetch data
l_arvalid  in  1  load read request
l_araddr  in  ADDR_W  load address
l_arlen  in  LEN_W  load burst length minus 1
l_arready  out  1  load request accepted
l_rvalid  out  1  load data beat valid
l_rlast  out  1  load last beat
l_rready  in  1  load can accept a beat
rdata  out  DATA_W  shared read data to both requesters (qualified by each port's rvalid)
m_arvalid  out  1  memory address valid
m_araddr  out  ADDR_W  memory address
m_arlen  out  LEN_W  memory burst length
m_arsize  out  3  constant 3'd3 (8 bytes per beat)
m_arburst  out  2  constant 2'b01 (INCR)
m_arready  in  1  memory accepts address
m_rvalid  in  1  memory data valid
m_rdata  in  DATA_W  memory data
m_rlast  in  1  memory last beat
m_rready  out  1  arbiter accepts beat
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; m_arvalid=0; m_araddr=0; m_arlen=0; f_arready=l_arready=0; grant=F; last_grant=L, so F wins the first tie; drop=0. All R-side outputs are 0, as they derive from state.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrate when f_arvalid or l_arvalid is high. A single requester wins outright.
  - If both request, round-robin: the requester opposite last_grant wins.
  - A flushed fetch request (f_arvalid & f_flush in the same cycle) is ignored.
  - On winning, pulse the winner's arready for 1 cycle (combinational in IDLE) and register addr/len into m_araddr/m_arlen.
  - Set grant and last_grant, then go to ADDR. m_arvalid rises the next cycle, so request-to-AR latency is 1 cycle.
- ADDR:
  - m_arvalid=1; m_araddr/m_arlen stay stable until m_arready (AXI rule: arvalid is never withdrawn).
  - On m_arvalid&m_arready: m_arvalid=0 next cycle, go to DATA.
- DATA:
  - Route the R channel to the granted port: g_rvalid=m_rvalid&!drop, g_rlast=m_rlast, rdata=m_rdata.
  - m_rready = drop ? 1 : g_rready. The non-granted port's rvalid is 0.
  - On m_rvalid&m_rready&m_rlast: go to IDLE and clear drop.
  - A new arbitration happens in IDLE, giving a minimum of 1 idle cycle between bursts.
- Flush:
  - f_flush while grant=F in ADDR or DATA sets drop=1 (sticky until the burst ends).
  - With drop set, all remaining beats are sunk with m_rready=1 and f_rvalid is forced to 0, including the beat in the flush cycle.
  - f_flush while grant=L has no effect on the burst.
- Same-cycle events:
  - Flush on the rlast beat: the beat is discarded and the state returns to IDLE normally.
  - New requests during ADDR/DATA wait; requesters hold arvalid.
- Burst length: m_arlen=0 gives a single beat; the arbiter does not count beats and relies on m_rlast.
- Reset mid-burst: the state returns immediately to IDLE. The memory side must also be reset by the same rst_n.

Decomposition:
- Shared package axi_pkg:
  - localparams ARB_IDLE/ARB_ADDR/ARB_DATA (2-bit state encoding).
  - AXI_BURST_INCR=2'b01, AXI_SIZE_8B=3'd3.
  - REQ_F=1'b0, REQ_L=1'b1.
- One sub-module: rr_arb2, a 2-input round-robin picker (inputs: req[1:0], last_grant; output: grant index, valid). Purely combinational; the last_grant register lives in the parent.

Test Plan:
- F only, addr 0x100, len 1 → f_arready pulse cycle 0; m_arvalid cycle 1 with m_araddr=0x100, m_arlen=1; 2 beats forwarded to F; f_rlast on the 2nd beat; l_rvalid stays 0.
- F and L request simultaneously after reset (F 0x200, L 0x800) → F granted first. L is issued after F's rlast + 1 idle cycle. Next tie goes to L (alternation checked over 4 rounds).
- m_arready held low 5 cycles → m_arvalid, m_araddr and m_arlen stay constant all 5 cycles; DATA is entered only after the handshake.
- F burst len 3, f_flush asserted on beat 1 → beats 1-3 are sunk (m_rready=1); f_rvalid=0 from beat 1 onward; state returns to IDLE after rlast; the following L request proceeds normally.
- L backpressure: l_rready=0 for 3 cycles while m_rvalid=1 → m_rready=0 and the beat is held, then transferred once l_rready=1; rdata matches m_rdata.
- rst_n dropped during DATA → asynchronously m_arvalid=0, m_rready=0, busy=0; after release, a fresh F request is granted normally.
